// File: rtl/mem_load_resp_queue.sv
// mem_load_resp_queue: in-order MEM-stage response queue with load extraction (optional MEM_RESP_BYPASS_EN: zero-latency head bypass)
module mem_load_resp_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_fire,
    input  logic                  req_is_load,
    input  logic [4:0]            req_ld_op,
    input  logic [OFF_W-1:0]      req_offset,
    input  logic [4:0]            req_dest,
    output logic                  req_ready,
    input  logic                  data_ok,
    input  logic [DATA_W-1:0]     rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_we,
    output logic [4:0]            out_dest,
    output logic [31:0]           out_data,
    input  logic                  flush,
    output logic                  fwd_busy,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                  resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = OFF_W + 3;

    logic [PW-1:0]    wr_ptr_q, rs_ptr_q, rd_ptr_q, cancel_q;
    logic [PW-1:0]    wr_ptr_d, rs_ptr_d, rd_ptr_d, cancel_d;
    logic             resp_err_q, resp_err_d;
    logic [DEPTH-1:0] is_load_q, done_q;
    logic [4:0]       ld_op_q [DEPTH];
    logic [OFF_W-1:0] off_q   [DEPTH];
    logic [4:0]       dest_q  [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [AW-1:0]    wr_idx, rs_idx, rd_idx;
    logic [PW-1:0]    live, pend;
    logic             alloc, hit_cancel, hit_entry, bad_resp, head_done, bypass, retire;
    logic [31:0]      resp_val;

    function automatic logic [31:0] extract(input logic [DATA_W-1:0] d, input logic [4:0] op,
                                            input logic [OFF_W-1:0] off, input logic ld);
        logic [BW-1:0] sh;
        logic [7:0]    b;
        logic [15:0]   h;
        logic [31:0]   w;
        sh = {off, 3'b000};
        b  = 8'(d >> sh);
        h  = 16'(d >> (sh & ~BW'(15)));
        w  = 32'(d >> (sh & ~BW'(31)));
        return !ld ? 32'h0 : op[0] ? {{24{b[7]}}, b} : op[1] ? {{16{h[15]}}, h} : op[2] ? w :
               op[3] ? {24'h0, b} : op[4] ? {16'h0, h} : 32'h0;
    endfunction

    // Occupancy, response routing, head presentation and next-state pointers
    always_comb begin
        wr_idx      = wr_ptr_q[AW-1:0];
        rs_idx      = rs_ptr_q[AW-1:0];
        rd_idx      = rd_ptr_q[AW-1:0];
        live        = wr_ptr_q - rd_ptr_q;
        pend        = wr_ptr_q - rs_ptr_q;
        outstanding = live + cancel_q;
        req_ready   = outstanding < PW'(DEPTH);
        alloc       = req_fire && req_ready;
        hit_cancel  = data_ok && cancel_q != '0;
        hit_entry   = data_ok && cancel_q == '0 && pend != '0;
        bad_resp    = data_ok && cancel_q == '0 && pend == '0;
        resp_val    = extract(rdata, ld_op_q[rs_idx], off_q[rs_idx], is_load_q[rs_idx]);
        head_done   = live != '0 && done_q[rd_idx] && !flush;
`ifdef MEM_RESP_BYPASS_EN
        bypass      = hit_entry && !flush && rs_ptr_q == rd_ptr_q;
`else
        bypass      = 1'b0;
`endif
        out_valid   = head_done || bypass;
        out_we      = out_valid && is_load_q[rd_idx];
        out_dest    = out_valid ? dest_q[rd_idx] : 5'd0;
        out_data    = bypass ? resp_val : head_done ? data_q[rd_idx] : 32'h0;
        retire      = out_valid && out_ready;
        fwd_busy    = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            fwd_busy |= (PW'(i) < live) && is_load_q[rd_idx + AW'(i)] && !done_q[rd_idx + AW'(i)];
        wr_ptr_d    = flush ? wr_ptr_q : wr_ptr_q + PW'(alloc);
        rs_ptr_d    = flush ? wr_ptr_q : rs_ptr_q + PW'(hit_entry);
        rd_ptr_d    = flush ? wr_ptr_q : rd_ptr_q + PW'(retire);
        cancel_d    = flush ? cancel_q + pend + PW'(alloc) - PW'(hit_cancel || hit_entry)
                            : cancel_q - PW'(hit_cancel);
        resp_err_d  = resp_err_q || bad_resp;
        resp_err    = resp_err_q;
    end

    // Pointers, cancel counter, sticky error and per-entry done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rs_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cancel_q   <= '0;
            resp_err_q <= 1'b0;
            done_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rs_ptr_q   <= rs_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cancel_q   <= cancel_d;
            resp_err_q <= resp_err_d;
            if (!flush && alloc)
                done_q[wr_idx] <= 1'b0;
            if (!flush && hit_entry && !(bypass && out_ready))
                done_q[rs_idx] <= 1'b1;
        end
    end

    // Entry payload: request fields on alloc, extracted result on response
    always_ff @(posedge clk) begin
        if (!flush && alloc) begin
            is_load_q[wr_idx] <= req_is_load;
            ld_op_q[wr_idx]   <= req_ld_op;
            off_q[wr_idx]     <= req_offset;
            dest_q[wr_idx]    <= req_dest;
        end
        if (!flush && hit_entry)
            data_q[rs_idx] <= resp_val;
    end
endmodule

// File: tb/tb_mem_load_resp_queue.sv
// tb_mem_load_resp_queue: directed and randomized checks of mem_load_resp_queue against a queue-based reference model
module tb_mem_load_resp_queue;
`ifdef MEM_RESP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [4:0] OP_B = 5'b00001, OP_H = 5'b00010, OP_W = 5'b00100,
                           OP_BU = 5'b01000, OP_HU = 5'b10000;

    logic        clk = 1'b0, reset = 1'b0;
    logic        req_fire = 0, req_is_load = 0, data_ok = 0, out_ready = 0, flush = 0;
    logic [4:0]  req_ld_op = 0, req_dest = 0;
    logic [1:0]  req_offset = 0;
    logic [31:0] rdata = 0;
    logic        req_ready, out_valid, out_we, fwd_busy, resp_err;
    logic [4:0]  out_dest;
    logic [31:0] out_data;
    logic [2:0]  outstanding;

    logic        w_fire = 0, w_is_load = 0, w_dok = 0, w_ordy = 0;
    logic [4:0]  w_op = 0, w_dest = 0;
    logic [2:0]  w_off = 0;
    logic [63:0] w_rdata = 0;
    logic        w_req_ready, w_valid, w_we, w_busy, w_err;
    logic [4:0]  w_odest;
    logic [31:0] w_data;
    logic [1:0]  w_outst;

    always #5 clk = ~clk;

    mem_load_resp_queue #(.DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req_fire(req_fire), .req_is_load(req_is_load),
        .req_ld_op(req_ld_op), .req_offset(req_offset), .req_dest(req_dest), .req_ready(req_ready),
        .data_ok(data_ok), .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_we(out_we), .out_dest(out_dest), .out_data(out_data), .flush(flush),
        .fwd_busy(fwd_busy), .outstanding(outstanding), .resp_err(resp_err));

    mem_load_resp_queue #(.DEPTH(2), .DATA_W(64)) dut64 (
        .clk(clk), .reset(reset), .req_fire(w_fire), .req_is_load(w_is_load),
        .req_ld_op(w_op), .req_offset(w_off), .req_dest(w_dest), .req_ready(w_req_ready),
        .data_ok(w_dok), .rdata(w_rdata), .out_valid(w_valid), .out_ready(w_ordy),
        .out_we(w_we), .out_dest(w_odest), .out_data(w_data), .flush(1'b0),
        .fwd_busy(w_busy), .outstanding(w_outst), .resp_err(w_err));

    typedef struct {
        logic        ld;
        logic [4:0]  op;
        logic [1:0]  off;
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t waitq[$];
    ent_t doneq[$];
    int   cancel = 0;
    bit   err = 0;
    bit   m_rdy, m_byp, m_valid;
    int   tests = 0, fails = 0;
    logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    function automatic logic [31:0] ref_ext(input logic [31:0] d, input ent_t e);
        logic [31:0] v;
        if (!e.ld) return 32'h0;
        if (e.op == OP_B || e.op == OP_BU) begin
            v = (d >> (8 * e.off)) & 32'hFF;
            if (e.op == OP_B && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (e.op == OP_H || e.op == OP_HU) begin
            v = (d >> (16 * (e.off / 2))) & 32'hFFFF;
            if (e.op == OP_H && v >= 32768) v = v + 32'hFFFF_0000;
        end else if (e.op == OP_W) v = d;
        else v = 32'h0;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit f, input bit l, input logic [4:0] op, input logic [1:0] off,
                         input logic [4:0] dst, input bit dok, input logic [31:0] rd,
                         input bit ordy, input bit fl);
        ent_t        h;
        logic [31:0] hd;
        bit          busy;
        int          live;
        req_fire = f; req_is_load = l; req_ld_op = op; req_offset = off; req_dest = dst;
        data_ok = dok; rdata = rd; out_ready = ordy; flush = fl;
        #1;
        live    = waitq.size() + doneq.size();
        m_rdy   = (live + cancel) < 4;
        m_byp   = BYP && dok && cancel == 0 && !fl && doneq.size() == 0 && waitq.size() > 0;
        m_valid = !fl && (doneq.size() > 0 || m_byp);
        h = '{ld: 1'b0, op: 5'd0, off: 2'd0, dest: 5'd0, data: 32'h0};
        hd = 32'h0;
        if (m_valid && doneq.size() > 0) begin h = doneq[0]; hd = h.data; end
        else if (m_valid) begin h = waitq[0]; hd = ref_ext(rd, h); end
        busy = 0;
        foreach (waitq[i]) busy |= waitq[i].ld;
        chk("out_valid", out_valid, m_valid);
        chk("out_we", out_we, m_valid && h.ld);
        chk("out_dest", out_dest, m_valid ? h.dest : 5'd0);
        chk("out_data", out_data, hd);
        chk("req_ready", req_ready, m_rdy);
        chk("outstanding", outstanding, live + cancel);
        chk("fwd_busy", fwd_busy, busy);
        chk("resp_err", resp_err, err);
    endtask

    task automatic idle(input bit ordy);
        drive(0, 0, 5'd0, 2'd0, 5'd0, 0, 32'h0, ordy, 0);
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (flush) begin
            cancel = cancel + waitq.size() + int'(req_fire && m_rdy)
                   - int'(data_ok && (cancel > 0 || waitq.size() > 0));
            waitq.delete();
            doneq.delete();
        end else begin
            if (data_ok) begin
                if (cancel > 0) cancel--;
                else if (waitq.size() > 0) begin
                    e = waitq.pop_front();
                    e.data = ref_ext(rdata, e);
                    if (!(m_byp && out_ready)) doneq.push_back(e);
                end else err = 1;
            end
            if (m_valid && out_ready && !m_byp) void'(doneq.pop_front());
            if (req_fire && m_rdy) begin
                e = '{ld: req_is_load, op: req_ld_op, off: req_offset, dest: req_dest, data: 32'h0};
                waitq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        req_fire = 0; data_ok = 0; flush = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        waitq.delete();
        doneq.delete();
        cancel = 0;
        err = 0;
    endtask

    initial begin
        bit          f, dok, fl, ordy;
        int          kind;
        logic [4:0]  op;
        logic [1:0]  off;
        do_reset();
        idle(1);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_outstanding", outstanding, 0);
        tick();
        drive(1, 1, OP_B, 2'd3, 5'd5, 0, 32'h0, 1, 0); tick();
        drive(0, 0, 5'd0, 2'd0, 5'd0, 1, 32'h80FF_0000, 0, 0); tick();
        idle(1);
        chk("ldb_valid", out_valid, 1);
        chk("ldb_data", out_data, 32'hFFFF_FF80);
        chk("ldb_we", out_we, 1);
        chk("ldb_dest", out_dest, 5'd5);
        tick();
        idle(1);
        chk("ldb_retired", out_valid, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, OP_W, 2'd0, 5'(i + 1), 0, 32'h0, 1, 0); tick();
        end
        drive(1, 1, OP_W, 2'd0, 5'd9, 0, 32'h0, 1, 0);
        chk("full_ready", req_ready, 0);
        chk("full_outstanding", outstanding, 4);
        chk("full_busy", fwd_busy, 1);
        tick();
        drive(0, 0, 5'd0, 2'd0, 5'd0, 1, vals[0], 0, 0); tick();
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 5'd0, 2'd0, 5'd0, 1, vals[i], 1, 0);
            chk("inorder_data", out_data, vals[i-1]);
            chk("inorder_dest", out_dest, 5'(i));
            tick();
        end
        idle(1);
        chk("inorder_last", out_data, 32'h44);
        tick();
        idle(1);
        chk("drained_outstanding", outstanding, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, OP_B, 2'(i), 5'(i + 20), 0, 32'h0, 1, 0); tick();
        end
        drive(1, 1, OP_W, 2'd0, 5'd7, 0, 32'h0, 1, 1);
        chk("flush_valid", out_valid, 0);
        tick();
        idle(1);
        chk("flush_cancel", outstanding, 4);
        chk("flush_ready", req_ready, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 5'd0, 2'd0, 5'd0, 1, $urandom, 1, 0); tick();
        end
        idle(1);
        chk("drop_err", resp_err, 0);
        chk("drop_outstanding", outstanding, 0);
        tick();
        drive(1, 1, OP_H, 2'd2, 5'd12, 0, 32'h0, 1, 0); tick();
        drive(0, 0, 5'd0, 2'd0, 5'd0, 1, 32'hF00D_0000, 0, 0); tick();
        idle(1);
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_data", out_data, 32'hFFFF_F00D);
        chk("post_flush_dest", out_dest, 5'd12);
        tick();
        drive(1, 1, OP_HU, 2'd2, 5'd7, 0, 32'h0, 0, 0); tick();
        drive(1, 0, 5'd0, 2'd0, 5'd9, 0, 32'h0, 0, 0); tick();
        drive(0, 0, 5'd0, 2'd0, 5'd0, 1, 32'hBEEF_1234, 0, 0); tick();
        drive(0, 0, 5'd0, 2'd0, 5'd0, 1, 32'hDEAD_BEEF, 0, 0); tick();
        for (int i = 0; i < 2; i++) begin
            idle(0);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 32'h0000_BEEF);
            chk("hold_dest", out_dest, 5'd7);
            tick();
        end
        idle(1);
        chk("hu_data", out_data, 32'h0000_BEEF);
        tick();
        idle(1);
        chk("st_valid", out_valid, 1);
        chk("st_we", out_we, 0);
        chk("st_data", out_data, 0);
        chk("st_dest", out_dest, 5'd9);
        tick();
        drive(0, 0, 5'd0, 2'd0, 5'd0, 1, 32'h1, 1, 0); tick();
        idle(1);
        chk("err_set", resp_err, 1);
        tick();
        idle(1);
        chk("err_sticky", resp_err, 1);
        tick();
        do_reset();
        idle(1);
        chk("err_cleared", resp_err, 0);
        tick();
        w_fire = 1; w_is_load = 1; w_op = OP_W; w_off = 3'd4; w_dest = 5'd3;
        @(posedge clk); #1;
        w_fire = 0; w_dok = 1; w_rdata = 64'h8765_4321_0000_0000; w_ordy = 1; #1;
`ifdef MEM_RESP_BYPASS_EN
        chk("w64_byp_valid", w_valid, 1);
        chk("w64_byp_data", w_data, 32'h8765_4321);
        @(posedge clk); #1;
        w_dok = 0; #1;
`else
        chk("w64_wait_valid", w_valid, 0);
        @(posedge clk); #1;
        w_dok = 0; #1;
        chk("w64_valid", w_valid, 1);
        chk("w64_data", w_data, 32'h8765_4321);
        chk("w64_dest", w_odest, 5'd3);
        @(posedge clk); #1;
`endif
        chk("w64_drained", w_valid, 0);
        w_fire = 1; w_op = OP_BU; w_off = 3'd7; w_dest = 5'd4; w_ordy = 0;
        @(posedge clk); #1;
        w_fire = 0; w_dok = 1; w_rdata = 64'hAB00_0000_0000_0000;
        @(posedge clk); #1;
        w_dok = 0; #1;
        chk("w64_bu_data", w_data, 32'h0000_00AB);
        w_ordy = 1;
        for (int n = 0; n < 400; n++) begin
            f    = $urandom_range(0, 2) != 0;
            kind = $urandom_range(0, 5);
            op   = kind == 0 ? OP_B : kind == 1 ? OP_H : kind == 2 ? OP_W :
                   kind == 3 ? OP_BU : kind == 4 ? OP_HU : 5'd0;
            off  = (kind == 0 || kind == 3) ? 2'($urandom_range(0, 3)) :
                   (kind == 1 || kind == 4) ? 2'(2 * $urandom_range(0, 1)) : 2'd0;
            dok  = (cancel > 0 || waitq.size() > 0) && $urandom_range(0, 1) == 1;
            fl   = $urandom_range(0, 19) == 0;
            ordy = $urandom_range(0, 3) != 0;
            drive(f, kind != 5, op, off, 5'($urandom), dok, $urandom, ordy, fl);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
